// File: rtl/fx_pkg.sv
// Shared constants and helpers for the fixed-point format-match pipeline.
package fx_pkg;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;
  localparam int SAT_WRAP      = 0;
  localparam int SAT_CLAMP     = 1;

  // Largest value representable in a w-bit signed word.
  function automatic longint fx_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  // Smallest value representable in a w-bit signed word.
  function automatic longint fx_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  // Intermediate width: input plus left-shift headroom plus one guard bit for rounding.
  function automatic int fx_w_int(input int in_w, input int shift);
    return in_w + ((shift > 0) ? shift : 0) + 1;
  endfunction

endpackage

// File: rtl/fx_pipe_reg.sv
// One elastic register slice: accepts new data whenever it is empty or its contents move on.
module fx_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         load_o,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;

  assign load_o = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_o) begin
      valid_d = valid_i;
      // Data only moves with a real sample so the output holds its last value when idle.
      if (valid_i) data_d = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fx_match_pipe.sv
// Two-stage fixed-point re-alignment (align/round, then overflow saturate/wrap) with
// valid/ready flow control and a saturating overflow event counter.
module fx_match_pipe
  import fx_pkg::*;
#(
  parameter int IN_W       = 14,
  parameter int IN_FRAC    = 10,
  parameter int OUT_W      = 12,
  parameter int OUT_FRAC   = 12,
  parameter int ROUND_MODE = 0,
  parameter int SAT_EN     = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [OUT_W-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_ovf,
  output logic [CNT_W-1:0] o_ovf_cnt,
  input  logic             i_cnt_clr
);

  localparam int SHIFT   = OUT_FRAC - IN_FRAC;
  localparam int W_INT   = fx_w_int(IN_W, SHIFT);
  localparam int LSH     = (SHIFT > 0) ? SHIFT : 0;
  localparam int K       = (SHIFT < 0) ? -SHIFT : 0;
  localparam int RND_BIT = (K > 0) ? K - 1 : 0;
  localparam int HALF_I  = (ROUND_MODE == ROUND_HALF_UP && K > 0) ? (1 << RND_BIT) : 0;
  localparam int CW      = (W_INT > OUT_W) ? W_INT : OUT_W;

  localparam logic signed [CW-1:0] MAX_C   = CW'(fx_max(OUT_W));
  localparam logic signed [CW-1:0] MIN_C   = CW'(fx_min(OUT_W));
  localparam logic [OUT_W-1:0]     OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]     OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  function automatic logic signed [W_INT-1:0] align_round(input logic signed [IN_W-1:0] x);
    logic signed [W_INT-1:0] ext;
    ext = W_INT'(x);
    if (SHIFT >= 0) return ext <<< LSH;
    ext = ext + W_INT'(HALF_I);
    return ext >>> K;
  endfunction

  // Returns {ovf, data}; ovf is reported identically in clamp and wrap modes.
  function automatic logic [OUT_W:0] quantize(input logic signed [W_INT-1:0] a);
    logic signed [CW-1:0] w;
    logic                 ovf;
    logic [OUT_W-1:0]     d;
    w   = CW'(a);
    ovf = (w > MAX_C) || (w < MIN_C);
    d   = w[OUT_W-1:0];
    if (ovf && SAT_EN == SAT_CLAMP) d = w[CW-1] ? OUT_MIN : OUT_MAX;
    return {ovf, d};
  endfunction

  logic signed [W_INT-1:0] align_p0;
  logic signed [W_INT-1:0] data_p1;
  logic                    vld_p1, load_p1;
  logic [OUT_W:0]          quant_p1;
  logic [OUT_W:0]          data_p2;
  logic                    vld_p2, load_p2;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  assign align_p0 = align_round(signed'(i_data));

  // ---- stage 1: aligned / rounded sample ----
  fx_pipe_reg #(.W(W_INT)) u_s1 (
    .clk     (clk),
    .rst     (rst),
    .valid_i (i_valid),
    .data_i  (align_p0),
    .ready_i (load_p2),
    .load_o  (load_p1),
    .valid_o (vld_p1),
    .data_o  (data_p1)
  );

  assign quant_p1 = quantize(data_p1);

  // ---- stage 2: overflow-resolved output word ----
  fx_pipe_reg #(.W(OUT_W + 1)) u_s2 (
    .clk     (clk),
    .rst     (rst),
    .valid_i (vld_p1),
    .data_i  (quant_p1),
    .ready_i (i_ready),
    .load_o  (load_p2),
    .valid_o (vld_p2),
    .data_o  (data_p2)
  );

  assign o_ready = load_p1;
  assign o_valid = vld_p2;
  assign o_data  = data_p2[OUT_W-1:0];
  assign o_ovf   = data_p2[OUT_W];

  always_comb begin
    cnt_d = cnt_q;
    if (i_cnt_clr)
      cnt_d = '0;
    else if (o_valid && i_ready && o_ovf && cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign o_ovf_cnt = cnt_q;

endmodule
